reg_file_sb: RTL

- Dual-bank (integer GPR / float FPR) register file with a busy-bit scoreboard.
- Answers the decode stage's read requests: `fmode1/reg1` and `fmode2/reg2` in, `reg_out1/reg_out2` out.
- Accepts writeback from the execute/memory stages.
- Tracks in-flight destinations so decode can stall on RAW hazards.
- Sits between decode and writeback in the core pipeline.

---
 rtl/core_pkg.sv | 19 +
 rtl/reg_bank.sv | 103 ++++++++++
 rtl/reg_file_sb.sv | 96 +++++++++
 3 files changed

// File: rtl/core_pkg.sv
// ============================================================================
//  Module   : core_pkg
//  Brief    : Shared core constants: register width, bank size and bank ids.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    localparam logic BANK_GPR = 1'b0;
    localparam logic BANK_FPR = 1'b1;

endpackage : core_pkg

`default_nettype wire

// File: rtl/reg_bank.sv
// ============================================================================
//  Module   : reg_bank
//  Brief    : One register bank with busy scoreboard and two read ports.
//             Same-cycle write-to-read forwarding when REG_FILE_BYPASS_EN
//             is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank
    import core_pkg::*;
#(
    parameter bit ZERO_REG = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [AW-1:0]   i_w_no,
    input  logic [XLEN-1:0] i_w_data,
    input  logic            i_rsv_en,
    input  logic [AW-1:0]   i_rsv_no,
    input  logic            i_flush,
    input  logic [AW-1:0]   i_rd_no1,
    input  logic [AW-1:0]   i_rd_no2,
    output logic [XLEN-1:0] o_rd_data1,
    output logic [XLEN-1:0] o_rd_data2,
    output logic            o_busy1,
    output logic            o_busy2
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;

    logic w_wr_ok;
    logic w_rsv_ok;
    logic w_rd_zero1;
    logic w_rd_zero2;

    // Register 0 of a zero-register bank is hardwired: it is never written,
    // never reserved, and always reads as idle zero.
    assign w_wr_ok    = i_we     && !(ZERO_REG && (i_w_no   == '0));
    assign w_rsv_ok   = i_rsv_en && !(ZERO_REG && (i_rsv_no == '0));
    assign w_rd_zero1 = ZERO_REG && (i_rd_no1 == '0);
    assign w_rd_zero2 = ZERO_REG && (i_rd_no2 == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[i_w_no] <= i_w_data;
            end
            if (i_flush) begin
                r_busy <= '0;
            end else begin
                if (w_wr_ok) begin
                    r_busy[i_w_no] <= 1'b0;
                end
                // Issued after the write clear so a same-register reserve
                // (the newer producer) leaves the bit set.
                if (w_rsv_ok) begin
                    r_busy[i_rsv_no] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_rd_data1 = r_regs[i_rd_no1];
        o_busy1    = r_busy[i_rd_no1];
`ifdef REG_FILE_BYPASS_EN
        if (w_wr_ok && (i_w_no == i_rd_no1)) begin
            o_rd_data1 = i_w_data;
            o_busy1    = 1'b0;
        end
`endif
        if (w_rd_zero1) begin
            o_rd_data1 = '0;
            o_busy1    = 1'b0;
        end
    end

    always_comb begin
        o_rd_data2 = r_regs[i_rd_no2];
        o_busy2    = r_busy[i_rd_no2];
`ifdef REG_FILE_BYPASS_EN
        if (w_wr_ok && (i_w_no == i_rd_no2)) begin
            o_rd_data2 = i_w_data;
            o_busy2    = 1'b0;
        end
`endif
        if (w_rd_zero2) begin
            o_rd_data2 = '0;
            o_busy2    = 1'b0;
        end
    end

endmodule : reg_bank

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ============================================================================
//  Module   : reg_file_sb
//  Brief    : Dual-bank (GPR/FPR) register file with busy-bit scoreboard.
//             Optional write bypass selected by REG_FILE_BYPASS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sb
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            fmode1,
    input  logic [AW-1:0]   reg1,
    input  logic            fmode2,
    input  logic [AW-1:0]   reg2,
    output logic [XLEN-1:0] reg_out1,
    output logic [XLEN-1:0] reg_out2,
    output logic            busy1,
    output logic            busy2,
    input  logic            rsv_en,
    input  logic            rsv_fmode,
    input  logic [AW-1:0]   rsv_no,
    input  logic            we,
    input  logic            w_fmode,
    input  logic [AW-1:0]   w_no,
    input  logic [XLEN-1:0] w_data,
    input  logic            flush
);

    logic            w_g_we;
    logic            w_f_we;
    logic            w_g_rsv;
    logic            w_f_rsv;
    logic [XLEN-1:0] w_g_data1;
    logic [XLEN-1:0] w_g_data2;
    logic [XLEN-1:0] w_f_data1;
    logic [XLEN-1:0] w_f_data2;
    logic            w_g_busy1;
    logic            w_g_busy2;
    logic            w_f_busy1;
    logic            w_f_busy2;

    // rstn is active-high despite its name.
    assign w_g_we  = we     && (w_fmode   == BANK_GPR);
    assign w_f_we  = we     && (w_fmode   == BANK_FPR);
    assign w_g_rsv = rsv_en && (rsv_fmode == BANK_GPR);
    assign w_f_rsv = rsv_en && (rsv_fmode == BANK_FPR);

    reg_bank #(
        .ZERO_REG   (1'b1)
    ) u_gpr (
        .clk        (clk),
        .rst        (rstn),
        .i_we       (w_g_we),
        .i_w_no     (w_no),
        .i_w_data   (w_data),
        .i_rsv_en   (w_g_rsv),
        .i_rsv_no   (rsv_no),
        .i_flush    (flush),
        .i_rd_no1   (reg1),
        .i_rd_no2   (reg2),
        .o_rd_data1 (w_g_data1),
        .o_rd_data2 (w_g_data2),
        .o_busy1    (w_g_busy1),
        .o_busy2    (w_g_busy2)
    );

    reg_bank #(
        .ZERO_REG   (1'b0)
    ) u_fpr (
        .clk        (clk),
        .rst        (rstn),
        .i_we       (w_f_we),
        .i_w_no     (w_no),
        .i_w_data   (w_data),
        .i_rsv_en   (w_f_rsv),
        .i_rsv_no   (rsv_no),
        .i_flush    (flush),
        .i_rd_no1   (reg1),
        .i_rd_no2   (reg2),
        .o_rd_data1 (w_f_data1),
        .o_rd_data2 (w_f_data2),
        .o_busy1    (w_f_busy1),
        .o_busy2    (w_f_busy2)
    );

    assign reg_out1 = (fmode1 == BANK_FPR) ? w_f_data1 : w_g_data1;
    assign busy1    = (fmode1 == BANK_FPR) ? w_f_busy1 : w_g_busy1;
    assign reg_out2 = (fmode2 == BANK_FPR) ? w_f_data2 : w_g_data2;
    assign busy2    = (fmode2 == BANK_FPR) ? w_f_busy2 : w_g_busy2;

endmodule : reg_file_sb

`default_nettype wire
